// File: rtl/hex_display_scan_pkg.sv
// Shared display types and the hex-to-segment decoder used by scan consumers.
package btc_disp_pkg;

    // Segment vector {g,f,e,d,c,b,a}, active-low (0 = segment lit).
    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'h7F;

    // Active-low common-anode glyphs for 0-F.
    function automatic seg7_t hex_to_seg(input logic [3:0] nib);
        seg7_t seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex_display_scan_if.sv
// Load channel for the display value.
// Handshake: a transfer happens on every clk edge where load_valid and load_ready
// are both 1. The master holds load_data stable and keeps load_valid high until
// that edge; load_ready may drop only as a result of a transfer.
interface hex_display_scan_if #(
    parameter int N_DIGITS = 8
);
    logic                    load_valid;
    logic [4*N_DIGITS-1:0]   load_data;
    logic                    load_ready;

    modport master (output load_valid, output load_data, input load_ready);
    modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/hex_display_scan_sync.sv
// Three-flop synchroniser with rising-edge detect for slow divided ticks.
// One rise_pulse per async_in rising edge, regardless of how long it stays high.
module tick_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise_pulse
);
    logic r_s1, r_s2, r_s3;

    // Shift the asynchronous tick through the synchroniser chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= async_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign rise_pulse = r_s2 & ~r_s3;
endmodule

// File: rtl/hex_display_scan.sv
// Multiplexed common-anode 7-segment scanner. Each synchronised tick advances one
// digit; new values arrive over a valid/ready channel and are swapped in only at
// the wrap from the last digit to digit 0 so a frame never shows mixed values.
module hex_display_scan
    import btc_disp_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter bit BLANK_LZ = 1'b1,
    localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick_in,
    hex_display_scan_if.slave    load_if,
    output logic [N_DIGITS-1:0]  an,
    output seg7_t                seg,
    output logic                 frame_done,
    output logic [IDX_W-1:0]     dbg_digit_idx,
    output logic                 dbg_pending
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

    logic                    w_tick;
    logic                    w_wrap;
    logic                    w_accept;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_frame_done;
    logic                    r_pending;
    logic [4*N_DIGITS-1:0]   r_pending_val;
    logic [4*N_DIGITS-1:0]   r_shown;
    logic [N_DIGITS-1:0]     r_an;
    seg7_t                   r_seg;
    logic [3:0]              w_nibs [N_DIGITS];
    logic [N_DIGITS-1:0]     w_upper_zero;
    logic                    w_blank;
    logic [N_DIGITS-1:0]     w_an_next;
    seg7_t                   w_seg_next;

    tick_edge_sync u_sync (
        .clk        (clk),
        .reset      (reset),
        .async_in   (tick_in),
        .rise_pulse (w_tick)
    );

    assign w_wrap             = w_tick & (r_idx == LAST_IDX);
    assign load_if.load_ready = ~r_pending;
    assign w_accept           = load_if.load_valid & ~r_pending;

    // Digit counter with explicit wrap (safe for non-power-of-two digit counts).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_wrap;
            if (w_tick) begin
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
            end
        end
    end

    // Load buffer: hold one value until the frame wraps; a load arriving exactly on
    // an idle wrap goes straight to the display.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending     <= 1'b0;
            r_pending_val <= '0;
            r_shown       <= '0;
        end else begin
            if (w_wrap && r_pending) begin
                r_shown   <= r_pending_val;
                r_pending <= 1'b0;
            end else if (w_wrap && w_accept) begin
                r_shown <= load_if.load_data;
            end else if (w_accept) begin
                r_pending_val <= load_if.load_data;
                r_pending     <= 1'b1;
            end
        end
    end

    // Split the shown word into nibbles and find which digits sit in the leading-zero run.
    always_comb begin
        w_upper_zero = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            w_nibs[k] = r_shown[4*k +: 4];
        end
        w_upper_zero[N_DIGITS-1] = (w_nibs[N_DIGITS-1] == 4'h0);
        for (int k = N_DIGITS - 2; k >= 0; k--) begin
            w_upper_zero[k] = w_upper_zero[k+1] & (w_nibs[k] == 4'h0);
        end
    end

    // Next anode/segment pattern for the current digit; digit 0 is never blanked.
    always_comb begin
        w_blank = BLANK_LZ && (r_idx != '0) && w_upper_zero[r_idx];
        for (int k = 0; k < N_DIGITS; k++) begin
            w_an_next[k] = (r_idx != IDX_W'(k));
        end
        w_seg_next = w_blank ? SEG_BLANK : hex_to_seg(w_nibs[r_idx]);
    end

    // Register an and seg together so they always switch on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_an  <= '1;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
        end
    end

    assign an            = r_an;
    assign seg           = r_seg;
    assign frame_done    = r_frame_done;
    assign dbg_digit_idx = r_idx;
    assign dbg_pending   = r_pending;
endmodule

// File: tb/tb_hex_display_scan.sv
// Directed bench for hex_display_scan: two instances (leading-zero blanking on/off)
// share clock, reset, tick and load stimulus.
module tb_hex_display_scan;
    logic       clk;
    logic       reset;
    logic       tick_in;
    int         checks;
    int         failures;

    logic [7:0] an_a, an_b;
    logic [6:0] seg_a, seg_b;
    logic       fd_a, fd_b;
    logic [2:0] idx_a, idx_b;
    logic       pend_a, pend_b;

    hex_display_scan_if #(.N_DIGITS(8)) if_a ();
    hex_display_scan_if #(.N_DIGITS(8)) if_b ();

    hex_display_scan #(.N_DIGITS(8), .BLANK_LZ(1'b1)) dut_a (
        .clk(clk), .reset(reset), .tick_in(tick_in), .load_if(if_a.slave),
        .an(an_a), .seg(seg_a), .frame_done(fd_a),
        .dbg_digit_idx(idx_a), .dbg_pending(pend_a)
    );

    hex_display_scan #(.N_DIGITS(8), .BLANK_LZ(1'b0)) dut_b (
        .clk(clk), .reset(reset), .tick_in(tick_in), .load_if(if_b.slave),
        .an(an_b), .seg(seg_b), .frame_done(fd_b),
        .dbg_digit_idx(idx_b), .dbg_pending(pend_b)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance n edges and land 1 ns after the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_load(input logic v, input logic [31:0] d);
        if_a.load_valid = v;
        if_a.load_data  = d;
        if_b.load_valid = v;
        if_b.load_data  = d;
    endtask

    // one full tick: high for one sample, then low long enough to re-arm the detector
    task automatic adv(input int n);
        repeat (n) begin
            tick_in = 1'b1;
            step(1);
            tick_in = 1'b0;
            step(4);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        tick_in  = 1'b0;
        drive_load(1'b0, 32'h0);

        // reset state
        step(2);
        check("rst_an", {24'h0, an_a}, 32'hFF);
        check("rst_seg", {25'h0, seg_a}, 32'h7F);
        check("rst_ready", {31'h0, if_a.load_ready}, 32'h1);
        check("rst_fd", {31'h0, fd_a}, 32'h0);
        reset = 1'b1;
        step(1);
        check("post_rst_an", {24'h0, an_a}, 32'hFE);
        check("post_rst_seg0", {25'h0, seg_a}, 32'h40);

        // latency: tick held high 20 cycles -> one advance
        tick_in = 1'b1;
        step(1);
        check("lat_e0_idx", {29'h0, idx_a}, 32'h0);
        step(1);
        check("lat_e1_idx", {29'h0, idx_a}, 32'h0);
        step(1);
        check("lat_e2_idx", {29'h0, idx_a}, 32'h1);
        check("lat_e2_an", {24'h0, an_a}, 32'hFE);
        step(1);
        check("lat_e3_an", {24'h0, an_a}, 32'hFD);
        check("lat_e3_seg_blank", {25'h0, seg_a}, 32'h7F);
        step(16);
        check("lat_hold_idx", {29'h0, idx_a}, 32'h1);
        tick_in = 1'b0;
        step(4);

        // load at digit 3, commit at wrap
        adv(2);
        check("ld_an_d3", {24'h0, an_a}, 32'hF7);
        drive_load(1'b1, 32'h1234ABCD);
        step(1);
        drive_load(1'b0, 32'h0);
        check("ld_ready_low", {31'h0, if_a.load_ready}, 32'h0);
        check("ld_seg_unchanged", {25'h0, seg_a}, 32'h7F);
        adv(4);
        check("ld_ready_held", {31'h0, if_a.load_ready}, 32'h0);
        tick_in = 1'b1;
        step(3);
        check("ld_fd", {31'h0, fd_a}, 32'h1);
        check("ld_idx_wrap", {29'h0, idx_a}, 32'h0);
        check("ld_ready_back", {31'h0, if_a.load_ready}, 32'h1);
        step(1);
        check("ld_fd_one_cycle", {31'h0, fd_a}, 32'h0);
        check("ld_an_d0", {24'h0, an_a}, 32'hFE);
        check("ld_seg_d0_D", {25'h0, seg_a}, 32'h21);
        tick_in = 1'b0;
        step(3);
        adv(7);
        check("ld_an_d7", {24'h0, an_a}, 32'h7F);
        check("ld_seg_d7_1", {25'h0, seg_a}, 32'h79);

        // bypass: load presented on the wrap cycle while idle
        tick_in = 1'b1;
        step(2);
        drive_load(1'b1, 32'h000000FF);
        check("byp_ready_pre", {31'h0, if_a.load_ready}, 32'h1);
        step(1);
        drive_load(1'b0, 32'h0);
        check("byp_ready", {31'h0, if_a.load_ready}, 32'h1);
        check("byp_pending", {31'h0, pend_a}, 32'h0);
        check("byp_fd", {31'h0, fd_a}, 32'h1);
        step(1);
        check("byp_seg_d0_F", {25'h0, seg_a}, 32'h0E);
        tick_in = 1'b0;
        step(3);
        adv(1);
        check("byp_seg_d1_F", {25'h0, seg_a}, 32'h0E);
        adv(1);
        check("byp_seg_d2_blank", {25'h0, seg_a}, 32'h7F);

        // back-pressure: second value held while pending
        drive_load(1'b1, 32'h00000A00);
        step(1);
        drive_load(1'b1, 32'h87654321);
        check("bp_ready_low", {31'h0, if_a.load_ready}, 32'h0);
        adv(5);
        check("bp_still_pending", {31'h0, pend_a}, 32'h1);
        tick_in = 1'b1;
        step(3);
        check("bp_fd", {31'h0, fd_a}, 32'h1);
        check("bp_ready_after_commit", {31'h0, if_a.load_ready}, 32'h1);
        step(1);
        drive_load(1'b0, 32'h0);
        check("bp_second_accepted", {31'h0, if_a.load_ready}, 32'h0);

        // blanking on shown = 0000_0A00
        check("blk_a_d0", {25'h0, seg_a}, 32'h40);
        check("blk_b_d0", {25'h0, seg_b}, 32'h40);
        tick_in = 1'b0;
        step(3);
        adv(1);
        check("blk_a_d1", {25'h0, seg_a}, 32'h40);
        adv(1);
        check("blk_a_d2_A", {25'h0, seg_a}, 32'h08);
        check("blk_b_d2_A", {25'h0, seg_b}, 32'h08);
        adv(1);
        check("blk_a_d3", {25'h0, seg_a}, 32'h7F);
        check("blk_b_d3", {25'h0, seg_b}, 32'h40);
        check("blk_an_d3", {24'h0, an_a}, 32'hF7);
        adv(4);
        check("blk_a_d7", {25'h0, seg_a}, 32'h7F);
        check("blk_b_d7", {25'h0, seg_b}, 32'h40);
        check("blk_an_b_d7", {24'h0, an_b}, 32'h7F);

        // second value shows one frame later
        tick_in = 1'b1;
        step(3);
        check("bp2_fd", {31'h0, fd_a}, 32'h1);
        check("bp2_ready", {31'h0, if_a.load_ready}, 32'h1);
        step(1);
        check("bp2_seg_d0_1", {25'h0, seg_a}, 32'h79);
        tick_in = 1'b0;
        step(3);
        adv(7);
        check("bp2_seg_d7_8", {25'h0, seg_a}, 32'h00);

        // asynchronous reset mid-frame with a value pending
        adv(2);
        drive_load(1'b1, 32'h00000055);
        step(1);
        drive_load(1'b0, 32'h0);
        check("mrst_pending_set", {31'h0, pend_a}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("mrst_an", {24'h0, an_a}, 32'hFF);
        check("mrst_seg", {25'h0, seg_a}, 32'h7F);
        check("mrst_ready", {31'h0, if_a.load_ready}, 32'h1);
        check("mrst_fd", {31'h0, fd_a}, 32'h0);
        check("mrst_idx", {29'h0, idx_a}, 32'h0);
        #2;
        reset = 1'b1;
        step(1);
        check("mrst_after_an", {24'h0, an_a}, 32'hFE);
        check("mrst_after_seg", {25'h0, seg_a}, 32'h40);
        check("mrst_after_pending", {31'h0, pend_a}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
